// File: rtl/lsu_pkg.sv
// lsu_pkg: access-width/state types and byte-lane helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {W_BYTE = 2'd0, W_HALF = 2'd1, W_WORD = 2'd2} width_t;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_t;
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    return (width == W_BYTE) ? 3'd1 : (width == W_HALF) ? 3'd2 : 3'd4;
  endfunction
  function automatic logic [7:0] strobe_mask(input logic [1:0] width, input logic [1:0] off);
    return ((width == W_BYTE) ? 8'h01 : (width == W_HALF) ? 8'h03 : 8'h0f) << off;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: per-beat write lane placement and split-read merge/shift/mask
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  off,
  input  logic        hi_beat,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  output logic [31:0] load_data
);
  logic [7:0]  strb;
  logic [5:0]  sh;
  logic [31:0] mask;
  assign sh         = {1'b0, off, 3'b000};
  assign strb       = strobe_mask(width, off);
  assign mask       = (width == W_BYTE) ? 32'h0000_00ff : (width == W_HALF) ? 32'h0000_ffff : 32'hffff_ffff;
  assign lane_wstrb = hi_beat ? strb[7:4] : strb[3:0];
  assign lane_wdata = hi_beat ? wdata >> (6'd32 - sh) : wdata << sh;
  assign load_data  = ((lo_word >> sh) | (hi_word << (6'd32 - sh))) & mask;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle word-bus load/store stage with misaligned split and per-beat timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_width,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_rdata
);
  lsu_state_t        state, nxt;
  logic              we_q, err_q, split, tmo;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, lo_q, rdata_q, lane_wdata, load_data;
  logic [1:0]        width_q;
  logic [7:0]        cnt;
  logic [3:0]        lane_wstrb;
  assign split     = ({2'b00, addr_q[1:0]} + {1'b0, byte_count(width_q)}) > 4'd4;
  assign tmo       = bus_valid && !bus_ready && cnt == 8'(TIMEOUT - 1);
  assign req_ready = state == IDLE;
  assign bus_valid = state == BEAT0 || state == BEAT1;
  assign rsp_valid = state == RESP;
  assign err       = rsp_valid && err_q;
  assign stall     = req_valid && !rsp_valid;
  assign rdata     = rdata_q;
  assign bus_we    = bus_valid && we_q;
  assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00} + ((state == BEAT1) ? ADDR_W'(4) : '0);
  assign bus_wstrb = bus_we ? lane_wstrb : 4'b0000;
  assign bus_wdata = bus_we ? lane_wdata : 32'h0;
  lsu_align u_align (
    .width      (width_q),
    .off        (addr_q[1:0]),
    .hi_beat    (state == BEAT1),
    .wdata      (wdata_q),
    .lo_word    ((state == BEAT1) ? lo_q : bus_rdata),
    .hi_word    (bus_rdata),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .load_data  (load_data)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? BEAT0 : IDLE;
      BEAT0:   nxt = bus_ready ? (split ? BEAT1 : RESP) : (tmo ? RESP : BEAT0);
      BEAT1:   nxt = (bus_ready || tmo) ? RESP : BEAT1;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 8'd1;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        width_q <= req_width;
      end
      if (state == BEAT0 && bus_ready) lo_q <= bus_rdata;
      if (nxt == RESP && state != RESP) begin
        err_q   <= tmo;
        rdata_q <= (tmo || we_q) ? 32'h0 : load_data;
      end
    end
  end
endmodule
